router_ctrl_fsm: RTL and testbench
==================================

Name: router_ctrl_fsm

Overview:
Packet-sequencing controller for the 1x3 router. It decodes the header address and drives the control strobes that step the synchronizer and register block through each packet: address detect, first-data load, payload load, full back-pressure and parity check. It sits between the input handshake (pkt_valid/busy) and the synchronizer, register block and three output FIFOs. It owns the single "packet in flight" resource and holds the source off via busy whenever that resource cannot accept data.

Parameters:
NUM_PORTS, 3, number of output FIFOs; the address encodings 0..NUM_PORTS-1 are valid.
ADDR_W, 2, header address width.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
pkt_valid  input  1  source asserts for header plus payload; deasserts on the parity byte
data_in  input  ADDR_W  header address bits, sampled only in DECODE_ADDRESS
parity_done  input  1  register block has captured the parity byte
low_pkt_valid  input  1  register block saw pkt_valid drop while the FIFO was full
fifo_full  input  1  addressed FIFO full (muxed by the synchronizer)
fifo_empty  input  NUM_PORTS  per-port FIFO empty flags
soft_reset  input  NUM_PORTS  per-port soft-reset pulses from the synchronizer timeout
busy  output  1  source must hold its data
detect_add  output  1  synchronizer latches the address this cycle
lfd_state  output  1  load first (header) byte
ld_state  output  1  load payload byte
laf_state  output  1  load the byte held during the full condition
full_state  output  1  FIFO-full hold state
write_enb_reg  output  1  FIFO write permitted
rst_int_reg  output  1  clear the internal parity/error registers
cur_addr  output  ADDR_W  latched packet address

Behaviour:
- State register and cur_addr update on posedge clk.
- Priority of next-state inputs: rst > soft_reset[cur_addr] (only in states other than DECODE_ADDRESS) > transition table below. Both rst and the soft-reset forcing send the FSM to DECODE_ADDRESS.
- rst: state=DECODE_ADDRESS, cur_addr=0. Outputs after reset: detect_add=1, busy=0, all other strobes 0.
- cur_addr loads data_in in DECODE_ADDRESS when pkt_valid=1 and data_in<NUM_PORTS. It holds in every other state.
- Transitions:
  - DECODE_ADDRESS: pkt_valid and valid address and fifo_empty[data_in] -> LOAD_FIRST_DATA. pkt_valid and valid address and !fifo_empty[data_in] -> WAIT_TILL_EMPTY. Otherwise stay; address 2'b11 is ignored.
  - WAIT_TILL_EMPTY: fifo_empty[cur_addr] -> LOAD_FIRST_DATA, else stay.
  - LOAD_FIRST_DATA: unconditional -> LOAD_DATA.
  - LOAD_DATA: fifo_full -> FIFO_FULL_STATE. Else !pkt_valid -> LOAD_PARITY. Else stay.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL, else stay.
  - LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS. Else low_pkt_valid -> LOAD_PARITY. Else -> LOAD_DATA.
  - LOAD_PARITY: unconditional -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
- Outputs are Moore and decoded combinationally from state only; no output depends on inputs.
  - detect_add = DECODE_ADDRESS
  - lfd_state = LOAD_FIRST_DATA
  - ld_state = LOAD_DATA
  - laf_state = LOAD_AFTER_FULL
  - full_state = FIFO_FULL_STATE
  - rst_int_reg = CHECK_PARITY_ERROR
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA
- Latency: header accepted in cycle N (DECODE_ADDRESS); lfd_state=1 in cycle N+1; ld_state=1 from N+2.
- A soft_reset pulse on a port other than cur_addr has no effect.
- A soft_reset[cur_addr] pulse arriving in the same cycle as a transition condition still forces DECODE_ADDRESS.
- Reset asserted mid-packet: DECODE_ADDRESS on the next edge. The partial packet is discarded by the datapath's own reset.
- The state encoding is 3-bit binary. The unused encodings must recover to DECODE_ADDRESS.

Decomposition:
- Shared package router_pkg holds:
  - state enumeration with fixed 3-bit encodings;
  - NUM_PORTS;
  - ADDR_W;
  - the constant ADDR_INVALID = 2'b11.
- No sub-module. The next-state logic, the cur_addr register and the output decode stay in one module. The cur_addr-indexed selection of fifo_empty and soft_reset is an inline mux.

Test Plan:
- Reset: assert rst for 2 cycles -> detect_add=1, busy=0, other strobes 0, cur_addr=0.
- Normal packet: data_in=2'b01, pkt_valid=1, fifo_empty=3'b111 -> next cycle lfd_state=1 and busy=1, then ld_state=1 and write_enb_reg=1. Drop pkt_valid -> LOAD_PARITY (busy=1, write_enb_reg=1) -> rst_int_reg=1 -> detect_add=1.
- Busy port: data_in=2'b10, fifo_empty=3'b011 (bit 2 clear) -> WAIT_TILL_EMPTY with busy=1 and write_enb_reg=0. Set fifo_empty[2]=1 -> lfd_state=1 next cycle.
- Full mid-payload: in LOAD_DATA raise fifo_full=1 -> full_state=1, busy=1 for as many cycles as held. Drop fifo_full -> laf_state=1.
  - With parity_done=0 and low_pkt_valid=0, the following cycle has ld_state=1.
  - With low_pkt_valid=1, the following cycle is LOAD_PARITY.
- Invalid address and soft reset:
  - data_in=2'b11 with pkt_valid=1 -> FSM stays in DECODE_ADDRESS and cur_addr is unchanged.
  - Mid-payload with cur_addr=0: soft_reset=3'b010 -> no effect; soft_reset=3'b001 -> detect_add=1 next cycle.

Source files
------------

// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 1x3 router control path.
//   NUM_PORTS    : number of output FIFOs (valid addresses 0..NUM_PORTS-1)
//   ADDR_W       : header address width
//   ADDR_INVALID : header address that never maps to a port
//   state_e      : controller state enumeration, fixed 3-bit binary codes
//   addr_is_valid: true when an address selects an existing port
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int NUM_PORTS = 3;
    localparam int ADDR_W    = 2;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

    function automatic logic addr_is_valid(input logic [ADDR_W-1:0] addr);
        return (addr != ADDR_INVALID) && (32'(addr) < 32'(NUM_PORTS));
    endfunction

endpackage

// File: rtl/router_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// router_ctrl_fsm_if
// Bundles the controller's handshake and strobe signals.
//   master : the controller side (consumes status, drives strobes)
//   slave  : the source / synchronizer / register-block side
// Status into the controller:
//   pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
//   fifo_empty[NUM_PORTS], soft_reset[NUM_PORTS]
// Strobes out of the controller:
//   busy, detect_add, lfd_state, ld_state, laf_state, full_state,
//   write_enb_reg, rst_int_reg, cur_addr
// -----------------------------------------------------------------------------
interface router_ctrl_fsm_if;
    import router_pkg::*;

    logic                  pkt_valid;
    logic [ADDR_W-1:0]     data_in;
    logic                  parity_done;
    logic                  low_pkt_valid;
    logic                  fifo_full;
    logic [NUM_PORTS-1:0]  fifo_empty;
    logic [NUM_PORTS-1:0]  soft_reset;

    logic                  busy;
    logic                  detect_add;
    logic                  lfd_state;
    logic                  ld_state;
    logic                  laf_state;
    logic                  full_state;
    logic                  write_enb_reg;
    logic                  rst_int_reg;
    logic [ADDR_W-1:0]     cur_addr;

    modport master (
        input  pkt_valid, data_in, parity_done, low_pkt_valid,
               fifo_full, fifo_empty, soft_reset,
        output busy, detect_add, lfd_state, ld_state, laf_state,
               full_state, write_enb_reg, rst_int_reg, cur_addr
    );

    modport slave (
        output pkt_valid, data_in, parity_done, low_pkt_valid,
               fifo_full, fifo_empty, soft_reset,
        input  busy, detect_add, lfd_state, ld_state, laf_state,
               full_state, write_enb_reg, rst_int_reg, cur_addr
    );

endinterface

// File: rtl/router_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// router_ctrl_fsm
// Packet-sequencing controller for the 1x3 router. Decodes the header address,
// steps the datapath through header / payload / full-hold / parity phases and
// holds the source off with busy whenever the packet path cannot take data.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : router_ctrl_fsm_if.master (status in, Moore strobes out)
// -----------------------------------------------------------------------------
module router_ctrl_fsm
    import router_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    router_ctrl_fsm_if.master  bus
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;

    // Port-selected status bits. Out-of-range indices read as 0, so an
    // invalid address can never select a phantom port.
    logic                empty_at_in;
    logic                empty_at_cur;
    logic                soft_at_cur;
    logic                hdr_ok;

    always_comb begin
        empty_at_in  = 1'b0;
        empty_at_cur = 1'b0;
        soft_at_cur  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (bus.data_in == ADDR_W'(i)) begin
                empty_at_in = bus.fifo_empty[i];
            end
            if (cur_addr_q == ADDR_W'(i)) begin
                empty_at_cur = bus.fifo_empty[i];
                soft_at_cur  = bus.soft_reset[i];
            end
        end
    end

    assign hdr_ok = bus.pkt_valid && addr_is_valid(bus.data_in);

    // ---------------- state / address register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DECODE_ADDRESS;
            cur_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;

        case (state_q)
            DECODE_ADDRESS: begin
                if (hdr_ok) begin
                    cur_addr_d = bus.data_in;
                    state_d    = empty_at_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (empty_at_cur) begin
                    state_d = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: begin
                state_d = LOAD_DATA;
            end
            LOAD_DATA: begin
                // Full takes precedence: the byte on the bus must be held
                // even if this is the last payload byte.
                if (bus.fifo_full) begin
                    state_d = FIFO_FULL_STATE;
                end else if (!bus.pkt_valid) begin
                    state_d = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) begin
                    state_d = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done) begin
                    state_d = DECODE_ADDRESS;
                end else if (bus.low_pkt_valid) begin
                    state_d = LOAD_PARITY;
                end else begin
                    state_d = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                state_d = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: begin
                state_d = DECODE_ADDRESS;
            end
        endcase

        // A timeout on the port owning the packet aborts it from any state
        // except the idle/decode state, overriding the table above.
        if (state_q != DECODE_ADDRESS && soft_at_cur) begin
            state_d = DECODE_ADDRESS;
        end
    end

    // ---------------- Moore output decode ----------------
    always_comb begin
        bus.detect_add    = 1'b0;
        bus.lfd_state     = 1'b0;
        bus.ld_state      = 1'b0;
        bus.laf_state     = 1'b0;
        bus.full_state    = 1'b0;
        bus.rst_int_reg   = 1'b0;
        bus.write_enb_reg = 1'b0;
        bus.busy          = 1'b1;

        case (state_q)
            DECODE_ADDRESS: begin
                bus.detect_add = 1'b1;
                bus.busy       = 1'b0;
            end
            LOAD_FIRST_DATA: begin
                bus.lfd_state = 1'b1;
            end
            LOAD_DATA: begin
                bus.ld_state      = 1'b1;
                bus.write_enb_reg = 1'b1;
                bus.busy          = 1'b0;
            end
            LOAD_AFTER_FULL: begin
                bus.laf_state     = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                bus.full_state = 1'b1;
            end
            LOAD_PARITY: begin
                bus.write_enb_reg = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                bus.rst_int_reg = 1'b1;
            end
            default: begin
                // WAIT_TILL_EMPTY: busy only
            end
        endcase
    end

    assign bus.cur_addr = cur_addr_q;

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_router_ctrl_fsm
// Directed stimulus for router_ctrl_fsm. Each stimulus step queues the
// expected post-edge strobe pattern; an independent monitor pops and compares
// one entry shortly after every rising edge.
// -----------------------------------------------------------------------------
module tb_router_ctrl_fsm;

    logic clk = 1'b0;
    logic rst;

    router_ctrl_fsm_if bus ();

    router_ctrl_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Bench-side state names (independent of the RTL enum).
    localparam int S_DA  = 0;  // decode address
    localparam int S_WTE = 1;  // wait till empty
    localparam int S_LFD = 2;  // load first data
    localparam int S_LD  = 3;  // load data
    localparam int S_FFS = 4;  // fifo full hold
    localparam int S_LAF = 5;  // load after full
    localparam int S_LP  = 6;  // load parity
    localparam int S_CPE = 7;  // check parity error

    typedef struct {
        logic [9:0] vec;   // {busy,detect,lfd,ld,laf,full,wen,rst_int,addr[1:0]}
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Expected strobe pattern per state, straight from the output table.
    function automatic logic [7:0] strobes(input int st);
        //                  busy det lfd ld laf full wen rsti
        case (st)
            S_DA:  return 8'b0_1_0_0_0_0_0_0;
            S_WTE: return 8'b1_0_0_0_0_0_0_0;
            S_LFD: return 8'b1_0_1_0_0_0_0_0;
            S_LD:  return 8'b0_0_0_1_0_0_1_0;
            S_FFS: return 8'b1_0_0_0_0_1_0_0;
            S_LAF: return 8'b1_0_0_0_1_0_1_0;
            S_LP:  return 8'b1_0_0_0_0_0_1_0;
            default: return 8'b1_0_0_0_0_0_0_1; // S_CPE
        endcase
    endfunction

    // Queue the expectation for the coming edge, then let that edge happen.
    task automatic cyc(input int st, input logic [1:0] addr, input string nm);
        exp_t e;
        e.vec  = {strobes(st), addr};
        e.name = nm;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: the FSM presents a new output every cycle.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [9:0] got;
            e   = exp_q.pop_front();
            got = {bus.busy, bus.detect_add, bus.lfd_state, bus.ld_state,
                   bus.laf_state, bus.full_state, bus.write_enb_reg,
                   bus.rst_int_reg, bus.cur_addr};
            total++;
            if (got !== e.vec) begin
                bad++;
                $display("FAIL %s: got=%b want=%b (busy det lfd ld laf full wen rsti addr)",
                         e.name, got, e.vec);
            end else begin
                $display("ok   %s: %b", e.name, got);
            end
        end
    end

    initial begin
        rst               = 1'b1;
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'b00;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty    = 3'b111;
        bus.soft_reset    = 3'b000;
        @(negedge clk);

        // Reset
        cyc(S_DA, 2'd0, "reset_1");
        cyc(S_DA, 2'd0, "reset_2");
        rst = 1'b0;
        cyc(S_DA, 2'd0, "idle_no_valid");

        // Normal packet to port 1
        bus.pkt_valid = 1'b1; bus.data_in = 2'b01;
        cyc(S_LFD, 2'd1, "p1_lfd");
        bus.data_in = 2'b10;               // payload bits must not move cur_addr
        cyc(S_LD,  2'd1, "p1_ld_a");
        cyc(S_LD,  2'd1, "p1_ld_b");
        bus.pkt_valid = 1'b0;
        cyc(S_LP,  2'd1, "p1_parity");
        cyc(S_CPE, 2'd1, "p1_check");
        cyc(S_DA,  2'd1, "p1_done");

        // Busy port 2: wait until its FIFO drains
        bus.fifo_empty = 3'b011; bus.pkt_valid = 1'b1; bus.data_in = 2'b10;
        cyc(S_WTE, 2'd2, "p2_wait_a");
        cyc(S_WTE, 2'd2, "p2_wait_b");
        bus.fifo_empty = 3'b111;
        cyc(S_LFD, 2'd2, "p2_lfd");
        cyc(S_LD,  2'd2, "p2_ld");

        // Full mid-payload, resume to payload
        bus.fifo_full = 1'b1;
        cyc(S_FFS, 2'd2, "full_a");
        cyc(S_FFS, 2'd2, "full_b");
        bus.fifo_full = 1'b0;
        cyc(S_LAF, 2'd2, "laf_1");
        cyc(S_LD,  2'd2, "laf_to_ld");

        // Full again, then low_pkt_valid routes to parity
        bus.fifo_full = 1'b1;
        cyc(S_FFS, 2'd2, "full_c");
        bus.fifo_full = 1'b0;
        cyc(S_LAF, 2'd2, "laf_2");
        bus.low_pkt_valid = 1'b1;
        cyc(S_LP,  2'd2, "laf_to_lp");
        bus.low_pkt_valid = 1'b0; bus.pkt_valid = 1'b0;
        cyc(S_CPE, 2'd2, "p2_check");

        // Full during parity check, then parity_done ends the packet
        bus.fifo_full = 1'b1;
        cyc(S_FFS, 2'd2, "cpe_to_full");
        bus.fifo_full = 1'b0;
        cyc(S_LAF, 2'd2, "laf_3");
        bus.parity_done = 1'b1;
        cyc(S_DA,  2'd2, "laf_parity_done");
        bus.parity_done = 1'b0;

        // Invalid address is ignored, cur_addr kept
        bus.pkt_valid = 1'b1; bus.data_in = 2'b11;
        cyc(S_DA, 2'd2, "bad_addr_a");
        cyc(S_DA, 2'd2, "bad_addr_b");

        // Soft reset: other port ignored, own port aborts
        bus.data_in = 2'b00;
        cyc(S_LFD, 2'd0, "p0_lfd");
        cyc(S_LD,  2'd0, "p0_ld");
        bus.soft_reset = 3'b010;
        cyc(S_LD,  2'd0, "soft_other");
        bus.soft_reset = 3'b001;
        cyc(S_DA,  2'd0, "soft_own");
        // Soft reset does not act in decode: header still accepted
        cyc(S_LFD, 2'd0, "soft_in_decode");
        // Soft reset beats the unconditional LFD->LD step
        cyc(S_DA,  2'd0, "soft_vs_lfd");
        bus.soft_reset = 3'b000;
        cyc(S_LFD, 2'd0, "p0b_lfd");
        cyc(S_LD,  2'd0, "p0b_ld");

        // Reset mid-packet
        rst = 1'b1;
        cyc(S_DA, 2'd0, "rst_mid_pkt");
        rst = 1'b0; bus.pkt_valid = 1'b0;
        cyc(S_DA, 2'd0, "after_rst");

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got=%0d pending want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
